// File: rtl/twiddle_gen_qw_if.sv
// Stage-side bundle for twiddle_gen_qw: sample strobes in, twiddle and select out.
// The inv signal exists only when TWIDDLE_GEN_QW_INV_EN is defined.
interface twiddle_gen_qw_if #(
  parameter int DATA_W = 16
);
  logic                     in_valid;
  logic                     frame_start;
`ifdef TWIDDLE_GEN_QW_INV_EN
  logic                     inv;
`endif
  logic signed [DATA_W-1:0] tw_re;
  logic signed [DATA_W-1:0] tw_im;
  logic                     tw_valid;
  logic                     tw_sel;

  modport master (
`ifdef TWIDDLE_GEN_QW_INV_EN
    output inv,
`endif
    output in_valid, frame_start,
    input  tw_re, tw_im, tw_valid, tw_sel
  );

  modport slave (
`ifdef TWIDDLE_GEN_QW_INV_EN
    input  inv,
`endif
    input  in_valid, frame_start,
    output tw_re, tw_im, tw_valid, tw_sel
  );
endinterface

// File: rtl/twiddle_gen_qw.sv
// R2SDF twiddle generator: quarter-wave cosine table, symmetry decode, 3-cycle pipeline.
// Optional macro TWIDDLE_GEN_QW_INV_EN adds a per-sample conjugate (IFFT) control.
module twiddle_gen_qw #(
  parameter int DATA_W  = 16,
  parameter int LOG2_N  = 10,
  parameter int STAGE   = 0,
  parameter     TW_FILE = "tw_cos_qw.txt"
) (
  input  logic              clk,
  input  logic              rst,
  twiddle_gen_qw_if.slave   tw_if
);
  localparam int N       = 1 << LOG2_N;
  localparam int Q       = N / 4;
  localparam int AW      = LOG2_N - 1;
  localparam int SPAN    = N >> (STAGE + 1);
  localparam int SEL_BIT = LOG2_N - 1 - STAGE;

  if (LOG2_N < 3 || LOG2_N > 14 || STAGE < 0 || STAGE >= LOG2_N || $bits(TW_FILE) == 0) begin : g_bad_cfg
    $error("twiddle_gen_qw: illegal LOG2_N/STAGE/TW_FILE configuration");
  end

  // Table is computed at elaboration; TW_FILE names the equivalent hex image.
  function automatic int cos_q(input int m);
    real ang;
    ang = 2.0 * 3.14159265358979323846 * real'(m) / real'(N);
    return int'($cos(ang) * real'(1 << (DATA_W - 2)));
  endfunction

  logic signed [DATA_W-1:0] rom [0:Q];
  for (genvar gi = 0; gi <= Q; gi++) begin : g_rom
    assign rom[gi] = DATA_W'(cos_q(gi));
  end

  logic inv_s;
`ifdef TWIDDLE_GEN_QW_INV_EN
  assign inv_s = tw_if.inv;
`else
  assign inv_s = 1'b0;
`endif

  // Sample index and k decode
  logic [LOG2_N-1:0] cnt_q, cnt_d, idx;
  logic [AW-1:0]     k, a_re_d, a_im_d;
  logic              q_d;

  always_comb begin
    idx   = (tw_if.in_valid && tw_if.frame_start) ? '0 : cnt_q;
    cnt_d = cnt_q;
    if (tw_if.in_valid) begin
      cnt_d = idx + 1'b1;
    end
    k = AW'((idx & LOG2_N'(SPAN - 1)) << STAGE);
    // k[AW-1] set means k >= N/4 since k < N/2 always
    if (!k[AW-1]) begin
      q_d    = 1'b0;
      a_re_d = k;
      a_im_d = AW'(Q) - k;
    end else begin
      q_d    = 1'b1;
      a_re_d = AW'(N / 2 - int'(k));
      a_im_d = k - AW'(Q);
    end
  end

  logic [AW-1:0]            a_re_q, a_im_q;
  logic                     q1_q, sel1_q, v1_q, inv1_q;
  logic signed [DATA_W-1:0] c_re_q, c_im_q;
  logic                     q2_q, sel2_q, v2_q, inv2_q;
  logic signed [DATA_W-1:0] tw_re_q, tw_im_q;
  logic                     tw_sel_q, tw_valid_q;

  always_ff @(posedge clk) begin
    a_re_q <= a_re_d;
    a_im_q <= a_im_d;
    q1_q   <= q_d;
    sel1_q <= idx[SEL_BIT];
    inv1_q <= inv_s;
    c_re_q <= rom[a_re_q];
    c_im_q <= rom[a_im_q];
    q2_q   <= q1_q;
    sel2_q <= sel1_q;
    inv2_q <= inv1_q;
    if (rst) begin
      cnt_q      <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      tw_valid_q <= 1'b0;
      tw_sel_q   <= 1'b0;
      tw_re_q    <= '0;
      tw_im_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      v1_q       <= tw_if.in_valid;
      v2_q       <= v1_q;
      tw_valid_q <= v2_q;
      // Outputs hold between valid samples
      if (v2_q) begin
        tw_sel_q <= sel2_q;
        tw_re_q  <= q2_q ? -c_re_q : c_re_q;
        tw_im_q  <= inv2_q ? c_im_q : -c_im_q;
      end
    end
  end

  assign tw_if.tw_re    = tw_re_q;
  assign tw_if.tw_im    = tw_im_q;
  assign tw_if.tw_valid = tw_valid_q;
  assign tw_if.tw_sel   = tw_sel_q;
endmodule
